// File: rtl/wb_gpio_arb.sv
// Two-master round-robin Wishbone arbiter in front of the GPIO slave; the granted master keeps the bus while its cyc is high.
// Define WB_ARB_TIMEOUT_EN to add the watchdog that errors out transfers the slave never acknowledges.
module wb_gpio_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   cyc_raw, stb_raw;
  logic   wd_fire;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_gpio_arb: TIMEOUT must be in 2..255");
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i || wd_fire) state_d = IDLE;
      GNT1:    if (!m1_cyc_i || wd_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (state_q == GNT0) begin
      cyc_raw = m0_cyc_i;
      stb_raw = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (state_q == GNT1) begin
      cyc_raw = m1_cyc_i;
      stb_raw = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  // A watchdog hit drops the bus in the same cycle the error is reported.
  assign s_cyc_o  = cyc_raw & ~wd_fire;
  assign s_stb_o  = stb_raw & ~wd_fire;

  assign m0_ack_o = s_ack_i & (state_q == GNT0);
  assign m1_ack_o = s_ack_i & (state_q == GNT1);
  assign m0_err_o = wd_fire & (state_q == GNT0);
  assign m1_err_o = wd_fire & (state_q == GNT1);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;

  // Counts on the unmasked strobe; the masked one is itself a function of the count.
  assign wd_fire = (state_q != IDLE) && stb_raw && !s_ack_i && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = wd_cnt_q + 8'd1;
    if (state_q == IDLE || s_ack_i || !stb_raw || wd_fire) wd_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gpio_arb.sv
// Directed bench for wb_gpio_arb: a cycle table for arbitration/locking/reset plus a hung-slave sequence.
// A small registered-ack GPIO slave model sits behind the arbiter.
module tb_wb_gpio_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0]  s_sel_o;

  // Fixed per-master attributes: m0 writes 0x5A to 0x00, m1 reads 0x04.
  localparam logic [31:0] M0_ADR = 32'h0000_0000, M1_ADR = 32'h0000_0004;
  localparam logic [31:0] M0_DAT = 32'h0000_005A, M1_DAT = 32'h0000_0000;
  localparam logic [3:0]  M0_SEL = 4'h1, M1_SEL = 4'hF;

  wb_gpio_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(1'b1), .m0_adr_i(M0_ADR),
    .m0_sel_i(M0_SEL), .m0_dat_i(M0_DAT), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(1'b0), .m1_adr_i(M1_ADR),
    .m1_sel_i(M1_SEL), .m1_dat_i(M1_DAT), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  // GPIO slave model: ack one cycle after a strobe, deliberately unaffected by reset.
  logic        slv_ack = 1'b0;
  logic        hang    = 1'b0;
  logic [7:0]  gpio_q  = 8'h00;
  logic [31:0] slv_rdata = 32'h0;

  always @(posedge clk) begin
    slv_ack <= s_stb_o & ~slv_ack & ~hang;
    if (s_stb_o && !slv_ack) begin
      if (s_we_o) gpio_q <= s_dat_o[7:0];
      else        slv_rdata <= (s_adr_o == 32'h4) ? 32'h0000_00C3 : {24'h0, gpio_q};
    end
  end
  assign s_ack_i = slv_ack;
  assign s_dat_i = slv_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One row = one clock cycle: inputs held during it and outputs expected in it.
  typedef struct {
    logic       rst;
    logic       m0c, m0s, m1c, m1s;
    logic       cyc, stb;
    logic [1:0] own;       // 0 none, 1 m0, 2 m1 drives the slave address/data/we/sel
    logic       a0, a1;
    logic       dchk;      // read data 0xC3 expected on both masters
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic m0c, logic m0s, logic m1c, logic m1s,
                             logic cyc, logic stb, logic [1:0] own,
                             logic a0, logic a1, logic dchk);
    vec_t r;
    r.rst = rst; r.m0c = m0c; r.m0s = m0s; r.m1c = m1c; r.m1s = m1s;
    r.cyc = cyc; r.stb = stb; r.own = own; r.a0 = a0; r.a1 = a1; r.dchk = dchk;
    return r;
  endfunction

  function automatic logic [68:0] exp_bus(logic [1:0] own);
    case (own)
      2'd1:    return {1'b1, M0_SEL, M0_ADR, M0_DAT};
      2'd2:    return {1'b0, M1_SEL, M1_ADR, M1_DAT};
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic m0c, input logic m0s,
                       input logic m1c, input logic m1s);
    reset = rst; m0_cyc_i = m0c; m0_stb_i = m0s; m1_cyc_i = m1c; m1_stb_i = m1s;
  endtask

  task automatic do_reset();
    @(negedge clk); drive(1'b1, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    //           rst m0c m0s m1c m1s  cyc stb own a0 a1 dchk
    // m0 writes alone
    vecs.push_back(v(0, 1, 1, 0, 0,   0, 0, 0,  0, 0, 0));  // r0 request, IDLE
    vecs.push_back(v(0, 1, 1, 0, 0,   1, 1, 1,  0, 0, 0));  // r1 granted
    vecs.push_back(v(0, 1, 1, 0, 0,   1, 1, 1,  1, 0, 0));  // r2 ack
    vecs.push_back(v(0, 0, 0, 0, 0,   0, 0, 1,  0, 0, 0));  // r3 release
    vecs.push_back(v(0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0));  // r4 IDLE
    // reset, then simultaneous requests: m0 first
    vecs.push_back(v(1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0));  // r5
    vecs.push_back(v(0, 1, 1, 1, 1,   0, 0, 0,  0, 0, 0));  // r6
    vecs.push_back(v(0, 1, 1, 1, 1,   1, 1, 1,  0, 0, 0));  // r7
    vecs.push_back(v(0, 1, 0, 1, 1,   1, 0, 1,  1, 0, 0));  // r8 m0 ack
    vecs.push_back(v(0, 0, 0, 1, 1,   0, 0, 1,  0, 0, 0));  // r9 m0 drops cyc
    vecs.push_back(v(0, 0, 0, 1, 1,   0, 0, 0,  0, 0, 0));  // r10 one IDLE cycle
    vecs.push_back(v(0, 0, 0, 1, 1,   1, 1, 2,  0, 0, 0));  // r11 m1 granted
    vecs.push_back(v(0, 0, 0, 1, 0,   1, 0, 2,  0, 1, 1));  // r12 m1 ack
    vecs.push_back(v(0, 0, 0, 0, 0,   0, 0, 2,  0, 0, 0));  // r13
    // second simultaneous pair: m0 then m1 again
    vecs.push_back(v(0, 1, 1, 1, 1,   0, 0, 0,  0, 0, 0));  // r14
    vecs.push_back(v(0, 1, 1, 1, 1,   1, 1, 1,  0, 0, 0));  // r15
    vecs.push_back(v(0, 1, 0, 1, 1,   1, 0, 1,  1, 0, 0));  // r16
    vecs.push_back(v(0, 0, 0, 1, 1,   0, 0, 1,  0, 0, 0));  // r17
    vecs.push_back(v(0, 0, 0, 1, 1,   0, 0, 0,  0, 0, 0));  // r18
    vecs.push_back(v(0, 0, 0, 1, 1,   1, 1, 2,  0, 0, 0));  // r19
    vecs.push_back(v(0, 0, 0, 1, 0,   1, 0, 2,  0, 1, 1));  // r20 read 1
    // m1 keeps cyc for two more reads while m0 waits
    vecs.push_back(v(0, 1, 1, 1, 1,   1, 1, 2,  0, 0, 0));  // r21
    vecs.push_back(v(0, 1, 1, 1, 0,   1, 0, 2,  0, 1, 1));  // r22 read 2
    vecs.push_back(v(0, 1, 1, 1, 1,   1, 1, 2,  0, 0, 0));  // r23
    vecs.push_back(v(0, 1, 1, 1, 0,   1, 0, 2,  0, 1, 1));  // r24 read 3
    vecs.push_back(v(0, 1, 1, 0, 0,   0, 0, 2,  0, 0, 0));  // r25 m1 releases
    vecs.push_back(v(0, 1, 1, 0, 0,   0, 0, 0,  0, 0, 0));  // r26
    // reset in GNT0 with stb high; stale slave ack must be dropped
    vecs.push_back(v(1, 1, 1, 1, 1,   1, 1, 1,  0, 0, 0));  // r27
    vecs.push_back(v(0, 1, 1, 1, 1,   0, 0, 0,  0, 0, 0));  // r28 IDLE, stale ack
    vecs.push_back(v(0, 1, 1, 1, 1,   1, 1, 1,  0, 0, 0));  // r29 m0 re-granted
    vecs.push_back(v(0, 1, 0, 1, 1,   1, 0, 1,  1, 0, 0));  // r30
    vecs.push_back(v(0, 0, 0, 1, 1,   0, 0, 1,  0, 0, 0));  // r31
    vecs.push_back(v(0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0));  // r32

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s);
      #1;
      check($sformatf("r%0d s_cyc", i), 64'(s_cyc_o), 64'(vecs[i].cyc));
      check($sformatf("r%0d s_stb", i), 64'(s_stb_o), 64'(vecs[i].stb));
      check($sformatf("r%0d s_we_sel_adr", i), 64'({s_we_o, s_sel_o, s_adr_o}),
            64'(exp_bus(vecs[i].own) >> 32));
      check($sformatf("r%0d s_dat", i), 64'(s_dat_o), 64'(exp_bus(vecs[i].own) & 69'hFFFF_FFFF));
      check($sformatf("r%0d acks", i), 64'({m0_ack_o, m1_ack_o}), 64'({vecs[i].a0, vecs[i].a1}));
      check($sformatf("r%0d errs", i), 64'({m0_err_o, m1_err_o}), 64'd0);
      if (vecs[i].dchk) begin
        check($sformatf("r%0d m1_dat", i), 64'(m1_dat_o), 64'h0000_00C3);
        check($sformatf("r%0d m0_dat", i), 64'(m0_dat_o), 64'h0000_00C3);
      end
    end

    // Hung slave: m1 owns the bus, m0 waits.
    do_reset();
    hang = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0, 1, 1);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); drive(1'b0, 1, 1, 1, 1); #1;
      check($sformatf("wd c%0d m1_err", i), 64'(m1_err_o), 64'(i == 15));
      check($sformatf("wd c%0d m0_err", i), 64'(m0_err_o), 64'd0);
      check($sformatf("wd c%0d s_stb", i), 64'(s_stb_o), 64'(i < 15));
      check($sformatf("wd c%0d s_cyc", i), 64'(s_cyc_o), 64'(i < 15));
    end
    @(negedge clk); #1;
    check("wd m0 granted", 64'({s_cyc_o, s_we_o, s_adr_o}), 64'({1'b1, 1'b1, M0_ADR}));
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(1'b0, 1, 1, 1, 1); #1;
      check($sformatf("hang c%0d m1 holds", i), 64'({s_cyc_o, s_stb_o, s_we_o, s_adr_o}),
            64'({1'b1, 1'b1, 1'b0, M1_ADR}));
      check($sformatf("hang c%0d errs", i), 64'({m0_err_o, m1_err_o}), 64'd0);
    end
`endif
    hang = 1'b0;
    @(negedge clk); drive(1'b0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
